// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operand width, opcodes and FSM states.
package alu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_logic_core.sv
// Single-cycle combinational ALU for every opcode except SRL.
module alu_logic_core
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;

  assign is_sub  = (op == OP_SUB) || (op == OP_SLT);
  assign b_eff   = is_sub ? (~b + WIDTH'(1)) : b;
  assign sum     = a + b_eff;
  // Overflow uses the negated operand, so SUB and SLT share the ADD rule.
  assign sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOR: result = ~(a | b);
      OP_XOR: result = a ^ b;
      OP_ADD, OP_SUB: begin
        result   = sum;
        overflow = sum_ovf;
      end
      OP_SLT: result[0] = sum[WIDTH-1] ^ sum_ovf;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU stage: latches operands on start, shifts SRL one bit per cycle,
// and publishes registered res/zero/overflow with a one-cycle done pulse.
module alu_seq_unit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] core_res;
  logic             core_ovf;

  alu_logic_core u_core (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (core_res),
    .overflow (core_ovf)
  );

  // a_q doubles as the SRL working register; the core ignores it for SRL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      res      <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op;
            cnt   <= (op == OP_SRL) ? B[CNT_W-1:0] : '0;
            state <= S_EXEC;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_EXEC: begin
          if ((op_q == OP_SRL) && (cnt != '0)) begin
            a_q <= a_q >> 1;
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (op_q == OP_SRL) begin
              res      <= a_q;
              zero     <= (a_q == '0);
              overflow <= 1'b0;
            end else begin
              res      <= core_res;
              zero     <= (core_res == '0);
              overflow <= core_ovf;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit against a plain-arithmetic reference model.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] res;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;

  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  always #5 clk = ~clk;

  alu_seq_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .res      (res),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: result and overflow straight from the opcode rules.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic v);
    logic [31:0] nb;
    v  = 1'b0;
    nb = -b;
    case (o)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = ~(a | b);
      3'b011: r = a ^ b;
      3'b010: begin
        r = a + b;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b110: begin
        r = a + nb;
        v = (a[31] == nb[31]) && (r[31] != a[31]);
      end
      3'b111: begin
        r = a + nb;
        v = (a[31] == nb[31]) && (r[31] != a[31]);
        r = {31'b0, r[31] ^ v};
        v = 1'b0;
      end
      default: r = a >> b[4:0];
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
    return (o == 3'b101) ? 2 + int'(b[4:0]) : 2;
  endfunction

  // Issues one operation and reports what was observed; latency counts cycles after the start edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles,
                        output logic [31:0] r, output logic z, output logic v);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
    lat = -1; busy_cycles = 0;
    r = res; z = zero; v = overflow;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n; r = res; z = zero; v = overflow;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat, bc; logic [31:0] r; logic z, v;
    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    ntotal++;
    if ({res, zero, overflow, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state got res=%h z=%b v=%b busy=%b done=%b want 0/1/0/0/0",
               res, zero, overflow, busy, done);
    else npass++;
    rst = 1'b0;
    run_op(3'b001, 32'h0000_F0F0, 32'h0F0F_0000, lat, bc, r, z, v);
    ntotal++;
    if (lat !== 2) $display("FAIL or_latency got %0d want 2", lat); else npass++;
    ntotal++;
    if ({r, z, v} !== {32'h0F0F_F0F0, 1'b0, 1'b0})
      $display("FAIL or_result got %h z=%b v=%b want 0f0ff0f0 z=0 v=0", r, z, v);
    else npass++;
  endtask

  task automatic test_reset_with_start();
    int dones = 0;
    rst = 1'b1; start = 1'b1; op = 3'b010; A = 32'h1; B = 32'h1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    ntotal++;
    if ({res, zero, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL rst_beats_start got res=%h z=%b busy=%b done=%b want 0/1/0/0", res, zero, busy, done);
    else npass++;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    ntotal++;
    if (dones !== 0) $display("FAIL rst_beats_start_activity got %0d want 0", dones); else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [2:0]  ops [3] = '{3'b010, 3'b110, 3'b110};
    logic [31:0] as  [3] = '{32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'h0000_0001, 32'h1234_5678, 32'h0000_0001};
    logic [31:0] rs  [3] = '{32'h8000_0000, 32'h0, 32'h7FFF_FFFF};
    logic        zs  [3] = '{1'b0, 1'b1, 1'b0};
    logic        vs  [3] = '{1'b1, 1'b0, 1'b1};
    int lat, bc; logic [31:0] r; logic z, v;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bc, r, z, v);
      ntotal++;
      if ({r, z, v, lat} !== {rs[i], zs[i], vs[i], 32'sd2})
        $display("FAIL arith_%0d got res=%h z=%b v=%b lat=%0d want res=%h z=%b v=%b lat=2",
                 i, r, z, v, lat, rs[i], zs[i], vs[i]);
      else npass++;
    end
  endtask

  task automatic test_slt();
    int lat, bc; logic [31:0] r; logic z, v;
    run_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, lat, bc, r, z, v);
    ntotal++;
    if ({r, v} !== {32'h1, 1'b0}) $display("FAIL slt_neg_lt_pos got res=%h v=%b want 1 v=0", r, v);
    else npass++;
    run_op(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, lat, bc, r, z, v);
    ntotal++;
    if ({r, z, v} !== {32'h0, 1'b1, 1'b0}) $display("FAIL slt_pos_lt_neg got res=%h z=%b v=%b want 0 z=1 v=0", r, z, v);
    else npass++;
  endtask

  task automatic test_srl();
    int lat, bc; logic [31:0] r; logic z, v;
    run_op(3'b101, 32'h8000_0000, 32'd31, lat, bc, r, z, v);
    ntotal++;
    if (lat !== 33 || bc !== 32) $display("FAIL srl31_timing got lat=%0d busy=%0d want 33/32", lat, bc);
    else npass++;
    ntotal++;
    if ({r, z, v} !== {32'h1, 1'b0, 1'b0}) $display("FAIL srl31_result got %h z=%b v=%b want 1", r, z, v);
    else npass++;
    run_op(3'b101, 32'hDEAD_BEEF, 32'hFFFF_FFE0, lat, bc, r, z, v);
    ntotal++;
    if ({r, lat} !== {32'hDEAD_BEEF, 32'sd2}) $display("FAIL srl0 got res=%h lat=%0d want deadbeef lat=2", r, lat);
    else npass++;
    // Outputs must hold through idle cycles.
    repeat (5) @(posedge clk);
    #1;
    ntotal++;
    if ({res, zero, overflow, busy, done} !== {32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL idle_hold got res=%h z=%b v=%b busy=%b done=%b want deadbeef/0/0/0/0",
               res, zero, overflow, busy, done);
    else npass++;
  endtask

  task automatic test_busy_ignore();
    int dones = 0, lat = -1; logic [31:0] r = '0;
    start = 1'b1; op = 3'b101; A = 32'hF000_0000; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (done) begin dones++; lat = c; r = res; end
      @(posedge clk); #1;
      start = (c == 2); op = 3'b000; A = '0; B = '0;
    end
    start = 1'b0;
    ntotal++;
    if (dones !== 1 || lat !== 6) $display("FAIL busy_ignore_done got count=%0d lat=%0d want 1/6", dones, lat);
    else npass++;
    ntotal++;
    if (r !== 32'h0F00_0000) $display("FAIL busy_ignore_result got %h want 0f000000", r);
    else npass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, e1, e2; logic v1, v2, ev1, ev2;
    int l1 = -1, l2 = -1;
    model(3'b010, 32'h0000_0005, 32'h0000_0007, e1, ev1);
    model(3'b011, 32'hA5A5_0000, 32'h5A5A_FFFF, e2, ev2);
    start = 1'b1; op = 3'b010; A = 32'h5; B = 32'h7;
    @(posedge clk); #1;
    start = 1'b0;
    r1 = res; v1 = overflow;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) begin l1 = n; r1 = res; v1 = overflow; break; end
    end
    // Still inside the DONE cycle: request the next operation.
    start = 1'b1; op = 3'b011; A = 32'hA5A5_0000; B = 32'h5A5A_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    r2 = res; v2 = overflow;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) begin l2 = n; r2 = res; v2 = overflow; break; end
    end
    @(posedge clk); #1;
    ntotal++;
    if ({r1, v1, l1} !== {e1, ev1, 32'sd2}) $display("FAIL b2b_first got res=%h v=%b lat=%0d want %h lat=2", r1, v1, l1, e1);
    else npass++;
    ntotal++;
    if ({r2, v2, l2} !== {e2, ev2, 32'sd2}) $display("FAIL b2b_second got res=%h v=%b lat=%0d want %h lat=2", r2, v2, l2, e2);
    else npass++;
  endtask

  task automatic test_reset_mid();
    int dones = 0, lat, bc; logic [31:0] r; logic z, v;
    run_op(3'b011, 32'h1234_0000, 32'h0000_5678, lat, bc, r, z, v);
    start = 1'b1; op = 3'b101; A = 32'hC000_0001; B = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ntotal++;
    if ({res, zero, overflow, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_mid_state got res=%h z=%b v=%b busy=%b done=%b want 0/1/0/0/0",
               res, zero, overflow, busy, done);
    else npass++;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    @(posedge clk); #1;
    ntotal++;
    if (dones !== 0) $display("FAIL reset_mid_no_done got %0d want 0", dones); else npass++;
    run_op(3'b000, 32'hFFFF_0000, 32'h00FF_FF00, lat, bc, r, z, v);
    ntotal++;
    if ({r, z, lat} !== {32'h00FF_0000, 1'b0, 32'sd2}) $display("FAIL and_after_reset got %h z=%b lat=%0d want 00ff0000", r, z, lat);
    else npass++;
  endtask

  task automatic test_random();
    logic [2:0] o; logic [31:0] a, b, er, r; logic ev, z, v; int lat, bc, el;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      model(o, a, b, er, ev);
      el = exp_lat(o, b);
      run_op(o, a, b, lat, bc, r, z, v);
      ntotal++;
      if ({r, z, v} !== {er, (er == 32'h0), ev})
        $display("FAIL rand_%0d_result op=%b a=%h b=%h got %h z=%b v=%b want %h z=%b v=%b",
                 i, o, a, b, r, z, v, er, (er == 32'h0), ev);
      else npass++;
      ntotal++;
      if (lat !== el || bc !== el - 1)
        $display("FAIL rand_%0d_timing op=%b got lat=%0d busy=%0d want %0d/%0d", i, o, lat, bc, el, el - 1);
      else npass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    test_reset();
    test_reset_with_start();
    test_arith();
    test_slt();
    test_srl();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Multi-cycle 32-bit ALU stage that consumes operand pairs and produces registered results for the datapath.
- It latches A, B and op on a start strobe, then evaluates the operation:
  - bitwise AND/OR/NOR/XOR, ADD/SUB and SLT in one execute cycle;
  - SRL iteratively, one bit per cycle.
- It presents res/zero/overflow with a one-cycle done pulse.
- It sits between the operand-select MUX stage and the register write-back path.

Parameters:
- WIDTH, 32, operand/result width. Fixed at 32; the shift counter is 5 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the unit can accept
- op  input  3  operation code, latched with start
- A  input  32  operand A, latched with start
- B  input  32  operand B, latched with start; B[4:0] is the SRL shift amount
- res  output  32  registered result, held until the next completion
- zero  output  1  res == 0, registered with res
- overflow  output  1  signed overflow for ADD/SUB, else 0
- busy  output  1  high while in EXEC
- done  output  1  one-cycle pulse when res/zero/overflow update

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state:
  - state=IDLE;
  - res=0, zero=1, overflow=0, busy=0, done=0;
  - internal operand, op and count registers = 0.
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT;
  - 100 NOR, 011 XOR, 101 SRL.
- States: IDLE, EXEC, DONE.
- IDLE or DONE with start=1:
  - latch A, B, op;
  - cnt <= B[4:0] if op==SRL, else 0;
  - next state EXEC.
- IDLE with start=0: stay IDLE.
- DONE with start=0: go IDLE.
- start is accepted in DONE, so back-to-back operations are possible.
- EXEC:
  - busy=1; start is ignored (not queued).
  - If op==SRL and cnt!=0: shift the working register right by 1 with zero fill, cnt <= cnt-1, stay EXEC.
  - Otherwise: register the final res, zero and overflow; go DONE.
- DONE: done=1 for exactly this cycle; busy=0.
- Latency (start edge at cycle k): done is high during cycle k+2+s, where s = shift amount for SRL and 0 for all other ops.
  - SRL by 0 therefore behaves like a single-cycle op.
- Outputs res, zero and overflow change only on the edge that enters DONE; they hold otherwise, including through IDLE.
- Arithmetic rules:
  - ADD/SUB: 32-bit wrap-around.
  - overflow = (sign(A)==sign(B') && sign(res)!=sign(A)), where B' = B for ADD and ~B+1 for SUB.
  - SLT: signed compare; res = {31'b0, sub_sign ^ sub_overflow}; overflow=0.
  - Logic ops and SRL: overflow=0.
- Illegal opcodes: none exist; all 8 codes are defined.
- Boundary conditions:
  - rst asserted mid-EXEC aborts the operation: next cycle IDLE, outputs at their reset values, no done pulse.
  - rst and start in the same cycle: rst wins.
  - SRL by 31 takes 32 EXEC cycles.
  - SUB of equal operands gives res=0 and zero=1.
  - Operand inputs may change freely after the start edge; the latched copies are used.

Decomposition:
- Shared package alu_pkg contains:
  - localparams for the 3-bit opcodes (OP_AND … OP_SRL);
  - state encodings (S_IDLE=2'd0, S_EXEC=2'd1, S_DONE=2'd2);
  - WIDTH.
- One combinational sub-module, alu_logic_core:
  - inputs: latched A, B, op;
  - outputs: single-cycle result and overflow for the non-shift ops.
  - It instantiates the existing 32-bit and/or primitives plus the adder.
- The FSM, shift register and counter live in alu_seq_unit.

Test Plan:
- Reset: hold rst 2 cycles -> res=0, zero=1, overflow=0, busy=0, done=0. Then start=1, op=001, A=32'h0000_F0F0, B=32'h0F0F_0000 -> done at k+2, res=32'h0F0F_F0F0, zero=0.
- ADD overflow: A=32'h7FFF_FFFF, B=32'h0000_0001, op=010 -> res=32'h8000_0000, overflow=1. SUB with A=B=32'h1234_5678 -> res=0, zero=1, overflow=0.
- SLT: A=32'hFFFF_FFFF (−1), B=32'h0000_0001 -> res=1. Swap the operands -> res=0. Both with overflow=0.
- SRL: A=32'h8000_0000, B=32'd31 -> busy high for 32 cycles, done at k+33, res=32'h0000_0001. B=0 -> done at k+2, res=A.
- Handshake: pulse start during EXEC of an SRL by 4 -> ignored, exactly one done. Start asserted in the DONE cycle -> accepted; second done pulse 2 cycles later for a non-shift op.
- Reset mid-op: rst in the 3rd EXEC cycle of an SRL by 10 -> IDLE next cycle, res=0, no done pulse. A subsequent AND of 32'hFFFF_0000 & 32'h00FF_FF00 -> res=32'h00FF_0000.
